// File: rtl/div_iter_if.sv
// rtl/div_iter_if.sv - request/result bundle between the EX stage and div_iter
//
// Purpose: groups the divider handshake and data signals.
//   master : start, signed_div, a, b, flush driven; busy, valid, quotient,
//            remainder, div_by_zero observed (pipeline / EX stage side)
//   slave  : the divider side, directions reversed
// Parameter WIDTH: operand, quotient and remainder width in bits.

interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_div, a, b, flush,
    input  busy, valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_div, a, b, flush,
    output busy, valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 restoring divider for MIPS DIV/DIVU
//
// Purpose: one quotient bit per cycle. Operand magnitudes are divided
// unsigned, then the quotient/remainder signs are fixed up on entry to DONE
// (quotient truncates toward zero, remainder takes the dividend's sign).
// Ports:
//   clk     in  rising-edge clock
//   resetn  in  asynchronous active-low reset
//   bus     div_iter_if.slave
//           start/signed_div/a/b  request, sampled only in IDLE
//           flush                 abort current op (beats start in IDLE)
//           busy                  state != IDLE
//           valid                 one-cycle result pulse
//           quotient/remainder    LO/HI values, held until the next DONE
//           div_by_zero           held result came from b == 0
// Build option: define DIV_ZERO_FAST_EN to send b == 0 straight from IDLE
// to DONE (valid one cycle after start) instead of the full iteration.

module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       resetn,
  div_iter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Iteration state: dvd_q shifts the dividend out of its top while the
  // quotient bits shift in at the bottom.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic             dz_q;

  // Held results
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remd_q;
  logic             dz_out_q;

  // Request decode
  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;

  assign accept = (state_q == S_IDLE) && bus.start && !bus.flush;
  assign a_neg  = bus.signed_div & bus.a[WIDTH-1];
  assign b_neg  = bus.signed_div & bus.b[WIDTH-1];
  assign a_mag  = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign b_mag  = b_neg ? (~bus.b + 1'b1) : bus.b;
  assign b_zero = (bus.b == '0);

  // One restoring step. The shifted partial remainder is WIDTH+1 bits and
  // is compared against the zero-extended divisor, so the subtract cannot
  // overflow; after a successful subtract the result always fits WIDTH bits.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   rem_wide;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dvd_step;
  logic             last;
  logic [WIDTH-1:0] quot_final;
  logic [WIDTH-1:0] rem_final;
  logic             unused_bits;

  assign shifted     = {rem_q, dvd_q[WIDTH-1]};
  assign q_bit       = (shifted >= {1'b0, dsr_q});
  assign rem_wide    = q_bit ? (shifted - {1'b0, dsr_q}) : shifted;
  assign rem_step    = rem_wide[WIDTH-1:0];
  assign unused_bits = rem_wide[WIDTH];
  assign dvd_step    = {dvd_q[WIDTH-2:0], q_bit};
  assign last        = (cnt_q == LAST_CNT);

  // Divide by zero naturally leaves rem = |a| and quotient = all ones; the
  // sign fix-up on the remainder restores the original a, but the quotient
  // must not be negated, hence the override.
  assign quot_final = dz_q ? '1 : (sign_q_q ? (~dvd_step + 1'b1) : dvd_step);
  assign rem_final  = sign_r_q ? (~rem_step + 1'b1) : rem_step;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          state_d = b_zero ? S_DONE : S_CALC;
`else
          state_d = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Iteration datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dvd_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      dz_q     <= 1'b0;
    end else if (accept) begin
      dvd_q    <= a_mag;
      dsr_q    <= b_mag;
      rem_q    <= '0;
      cnt_q    <= '0;
      sign_q_q <= a_neg ^ b_neg;
      sign_r_q <= a_neg;
      dz_q     <= b_zero;
    end else if (state_q == S_CALC && !bus.flush) begin
      dvd_q    <= dvd_step;
      rem_q    <= rem_step;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  // Held results: written only on the edge that enters DONE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quot_q   <= '0;
      remd_q   <= '0;
      dz_out_q <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
    end else if (accept && b_zero) begin
      quot_q   <= '1;
      remd_q   <= bus.a;
      dz_out_q <= 1'b1;
`endif
    end else if (state_q == S_CALC && !bus.flush && last) begin
      quot_q   <= quot_final;
      remd_q   <= rem_final;
      dz_out_q <= dz_q;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  // A flush landing in the DONE cycle suppresses the pulse.
  assign bus.valid       = (state_q == S_DONE) && !bus.flush;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remd_q;
  assign bus.div_by_zero = dz_out_q;

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - self-checking bench for div_iter

module tb_div_iter;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  div_iter_if #(.WIDTH(32)) bus ();

  div_iter #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one request, holds start until valid, returns the number of
  // clock edges from acceptance to valid and how many of those cycles had busy.
  task automatic do_op(input logic [31:0] a_v, input logic [31:0] b_v, input logic sgn,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    bus.a          = a_v;
    bus.b          = b_v;
    bus.signed_div = sgn;
    bus.start      = 1'b1;
    lat            = 0;
    busy_cnt       = 0;
    while (lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cnt++;
      if (bus.valid) break;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int exp_lat;
    int valid_cnt;
    int valid_cyc;
    logic [31:0] prev_q;
    logic [31:0] prev_r;

    errors = 0;
    checks = 0;

    //           a             b             sgn   q             r             dz
    vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0};
    vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0};
    vecs[5]  = '{32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 32'd5,        1'b1};
    vecs[6]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3,        32'hFFFFFFFF, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[8]  = '{32'd7,        32'd10,       1'b0, 32'd0,        32'd7,        1'b0};
    vecs[9]  = '{32'hFFFFFFFB, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
    vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1,        32'd0,        1'b0};
    vecs[11] = '{32'h7FFFFFFF, 32'd16,       1'b1, 32'h07FFFFFF, 32'd15,       1'b0};

    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.flush      = 1'b0;
    resetn         = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset_busy",  {31'd0, bus.busy},        32'd0);
    chk("reset_valid", {31'd0, bus.valid},       32'd0);
    chk("reset_q",     bus.quotient,             32'd0);
    chk("reset_r",     bus.remainder,            32'd0);
    chk("reset_dz",    {31'd0, bus.div_by_zero}, 32'd0);
    resetn = 1'b1;

    // Table-driven operations
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, lat, busy_cnt);
      exp_lat = vecs[i].dz ? DZ_LAT : 33;
      chk($sformatf("v%0d_latency", i), lat,                             exp_lat);
      chk($sformatf("v%0d_busy",    i), busy_cnt,                        exp_lat);
      chk($sformatf("v%0d_q",       i), bus.quotient,                    vecs[i].q);
      chk($sformatf("v%0d_r",       i), bus.remainder,                   vecs[i].r);
      chk($sformatf("v%0d_dz",      i), {31'd0, bus.div_by_zero},        {31'd0, vecs[i].dz});
      @(negedge clk);
      chk($sformatf("v%0d_valid_1cyc", i), {31'd0, bus.valid},           32'd0);
      chk($sformatf("v%0d_idle",    i), {31'd0, bus.busy},               32'd0);
      chk($sformatf("v%0d_q_held",  i), bus.quotient,                    vecs[i].q);
    end
    prev_q = vecs[11].q;
    prev_r = vecs[11].r;

    // Flush beats a simultaneous start in IDLE
    @(negedge clk);
    bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0;
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("flush_beats_start", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b0; bus.flush = 1'b0;

    // Flush in cycle 10, restart in cycle 12 -> valid in cycle 45
    bus.start = 1'b1;
    valid_cnt = 0;
    valid_cyc = 0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.valid) begin
        valid_cnt++;
        if (valid_cyc == 0) valid_cyc = cyc;
        bus.start = 1'b0;
      end
      if (cyc == 10) begin
        bus.start = 1'b0;
        bus.flush = 1'b1;
      end
      if (cyc == 11) begin
        bus.flush = 1'b0;
        chk("flush_idle",   {31'd0, bus.busy}, 32'd0);
        chk("flush_q_kept", bus.quotient,      prev_q);
        chk("flush_r_kept", bus.remainder,     prev_r);
      end
      if (cyc == 12) begin
        bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0;
        bus.start = 1'b1;
      end
    end
    bus.start = 1'b0;
    chk("flush_valid_count", valid_cnt,    1);
    chk("flush_valid_cycle", valid_cyc,    45);
    chk("restart_q",         bus.quotient, 32'd14);
    chk("restart_r",         bus.remainder, 32'd2);

    // Start pulses while busy are ignored; result uses the first operands
    @(negedge clk);
    bus.a = 32'hFFFFFFF9; bus.b = 32'd2; bus.signed_div = 1'b1;
    bus.start = 1'b1;
    valid_cyc = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.valid) begin
        valid_cyc = cyc;
        bus.start = 1'b0;
        break;
      end
      bus.a = 32'd1000 + cyc;
      bus.b = 32'd3;
      bus.signed_div = 1'b0;
      bus.start = cyc[0];
    end
    bus.start = 1'b0;
    chk("ignore_start_cycle", valid_cyc,    33);
    chk("ignore_start_q",     bus.quotient, 32'hFFFFFFFD);
    chk("ignore_start_r",     bus.remainder, 32'hFFFFFFFF);

    // Asynchronous reset mid-operation
    @(negedge clk);
    bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_busy",  {31'd0, bus.busy},        32'd0);
    chk("async_rst_valid", {31'd0, bus.valid},       32'd0);
    chk("async_rst_q",     bus.quotient,             32'd0);
    chk("async_rst_r",     bus.remainder,            32'd0);
    chk("async_rst_dz",    {31'd0, bus.div_by_zero}, 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    valid_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.valid) valid_cnt++;
    end
    chk("no_valid_after_reset", valid_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
